// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller slice.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_EXT,
    PH_YELLOW,
    PH_WALK
  } phase_t;

  // Per-road lamp codes, packed as {R,Y,G}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/traffic_interval_timer.sv
// Tick-driven down counter: a load of N gives N ticks before expiry (0 acts as 1).
module traffic_interval_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          expired
);

  always_ff @(posedge clk) begin
    if (load)
      count <= (load_val == '0) ? '0 : load_val - TW'(1);
    else if (tick && count != '0)
      count <= count - TW'(1);
  end

  assign expired = tick && (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic light controller with sensor extension and pedestrian walk phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_ROADS = 2,
  parameter int TW        = 4,
  parameter int T_BASE    = 6,
  parameter int T_EXT     = 3,
  parameter int T_YEL     = 2
) (
  input  logic                   clk,
  input  logic                   reset_sync,
  input  logic                   tick,
  input  logic [NUM_ROADS-1:0]   sensor_sync,
  input  logic                   wr,
  input  logic                   prog_sync,
  input  logic [1:0]             prog_sel,
  input  logic [TW-1:0]          prog_val,
  output logic [3*NUM_ROADS-1:0] lights,
  output logic                   walk,
  output logic [1:0]             active_road,
  output logic                   wr_pending
);

  phase_t        state, next_state;
  logic [1:0]    road, next_road, road_inc;
  logic [TW-1:0] base_int, ext_int, yel_int;
  logic          timer_load, expired, cur_sensor, enter_walk;
  logic [TW-1:0] timer_val, timer_count;

  traffic_interval_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (tick),
    .count    (timer_count),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state      <= PH_GREEN;
      road       <= 2'd0;
      base_int   <= TW'(T_BASE);
      ext_int    <= TW'(T_EXT);
      yel_int    <= TW'(T_YEL);
      wr_pending <= 1'b0;
    end else begin
      state <= next_state;
      road  <= next_road;
      if (prog_sync) begin
        case (prog_sel)
          SEL_BASE: base_int <= prog_val;
          SEL_EXT:  ext_int  <= prog_val;
          SEL_YEL:  yel_int  <= prog_val;
          SEL_NONE: ;
          default:  ;
        endcase
      end
      // A request arriving on the walk entry edge is kept for the next cycle
      if (enter_walk)
        wr_pending <= wr;
      else if (wr)
        wr_pending <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_road  = road;
    timer_load = 1'b0;
    timer_val  = base_int;
    cur_sensor = 1'b0;
    for (int k = 0; k < NUM_ROADS; k++)
      if (road == 2'(k)) cur_sensor = sensor_sync[k];
    road_inc = (road == 2'(NUM_ROADS - 1)) ? 2'd0 : road + 2'd1;

    // The timer has no reset of its own, so reset reloads it with the default green
    if (reset_sync) begin
      timer_load = 1'b1;
      timer_val  = TW'(T_BASE);
    end else if (prog_sync) begin
      next_state = PH_GREEN;
      next_road  = 2'd0;
      timer_load = 1'b1;
      timer_val  = (prog_sel == SEL_BASE) ? prog_val : base_int;
    end else if (expired) begin
      timer_load = 1'b1;
      case (state)
        PH_GREEN:
          if (cur_sensor) begin
            next_state = PH_EXT;
            timer_val  = ext_int;
          end else begin
            next_state = PH_YELLOW;
            timer_val  = yel_int;
          end
        PH_EXT: begin
          next_state = PH_YELLOW;
          timer_val  = yel_int;
        end
        PH_YELLOW:
          if (wr_pending) begin
            next_state = PH_WALK;
          end else begin
            next_state = PH_GREEN;
            next_road  = road_inc;
          end
        PH_WALK: begin
          next_state = PH_GREEN;
          next_road  = road_inc;
        end
        default: next_state = PH_GREEN;
      endcase
    end
    enter_walk = (next_state == PH_WALK) && (state != PH_WALK);
  end

  always_comb begin
    lights = '0;
    for (int k = 0; k < NUM_ROADS; k++) begin
      if (state == PH_WALK || road != 2'(k))
        lights[3*k +: 3] = LAMP_R;
      else if (state == PH_YELLOW)
        lights[3*k +: 3] = LAMP_Y;
      else
        lights[3*k +: 3] = LAMP_G;
    end
  end

  assign walk        = (state == PH_WALK);
  assign active_road = road;

  a_expiry_at_zero : assert property (@(posedge clk) expired |-> (timer_count == '0));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised and directed bench for traffic_phase_ctrl against a tick-budget reference model.
module tb_traffic_phase_ctrl;

  localparam int N  = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            reset_sync = 1'b1;
  logic            tick = 1'b0;
  logic [N-1:0]    sensor_sync = '0;
  logic            wr = 1'b0;
  logic            prog_sync = 1'b0;
  logic [1:0]      prog_sel = 2'd3;
  logic [TW-1:0]   prog_val = '0;
  logic [3*N-1:0]  lights;
  logic            walk;
  logic [1:0]      active_road;
  logic            wr_pending;

  int checks = 0;
  int passes = 0;

  // Reference model: phase name, road, pending flag, ticks left in phase, interval values
  string m_phase = "GREEN";
  int    m_road = 0;
  bit    m_pending = 0;
  int    m_left = 6;
  int    m_base = 6, m_ext = 3, m_yel = 2;

  traffic_phase_ctrl #(.NUM_ROADS(N), .TW(TW)) dut (
    .clk         (clk),
    .reset_sync  (reset_sync),
    .tick        (tick),
    .sensor_sync (sensor_sync),
    .wr          (wr),
    .prog_sync   (prog_sync),
    .prog_sel    (prog_sel),
    .prog_val    (prog_val),
    .lights      (lights),
    .walk        (walk),
    .active_road (active_road),
    .wr_pending  (wr_pending)
  );

  always #5 clk = ~clk;

  function automatic int ticks_of(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int interval_of(string ph);
    if (ph == "EXT") return ticks_of(m_ext);
    if (ph == "YELLOW") return ticks_of(m_yel);
    return ticks_of(m_base);
  endfunction

  task automatic model_update();
    bit entered_walk = 0;
    if (reset_sync) begin
      m_phase = "GREEN"; m_road = 0; m_pending = 0;
      m_base = 6; m_ext = 3; m_yel = 2; m_left = 6;
      return;
    end
    if (prog_sync) begin
      if (prog_sel == 2'd0) m_base = int'(prog_val);
      if (prog_sel == 2'd1) m_ext = int'(prog_val);
      if (prog_sel == 2'd2) m_yel = int'(prog_val);
      m_phase = "GREEN"; m_road = 0; m_left = ticks_of(m_base);
      if (wr) m_pending = 1;
      return;
    end
    if (tick) begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == "GREEN") m_phase = sensor_sync[m_road] ? "EXT" : "YELLOW";
        else if (m_phase == "EXT") m_phase = "YELLOW";
        else if (m_phase == "YELLOW" && m_pending) begin
          m_phase = "WALK"; entered_walk = 1;
        end else begin
          m_phase = "GREEN"; m_road = (m_road + 1) % N;
        end
        m_left = interval_of(m_phase);
      end
    end
    if (entered_walk) m_pending = wr;
    else if (wr) m_pending = 1;
  endtask

  function automatic logic [3*N+3:0] exp_vec();
    logic [3*N-1:0] l;
    for (int k = 0; k < N; k++) begin
      if (m_phase == "WALK" || k != m_road) l[3*k +: 3] = 3'b100;
      else if (m_phase == "YELLOW") l[3*k +: 3] = 3'b010;
      else l[3*k +: 3] = 3'b001;
    end
    return {l, (m_phase == "WALK"), 2'(m_road), m_pending};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_sync = 1'b1; prog_sync = 1'b0; wr = 1'b0; tick = 1'b1; sensor_sync = '0;
    step();
    reset_sync = 1'b0;
  endtask

  task automatic test_reset();
    reset_sync = 1'b1; tick = 1'b1; wr = 1'b1; sensor_sync = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL reset cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
    end
    checks++;
    if ({lights, walk, active_road, wr_pending} !== 10'b100001_0_00_0)
      $display("[TB] FAIL reset_const: got %b want %b", {lights, walk, active_road, wr_pending}, 10'b100001_0_00_0);
    else passes++;
    reset_sync = 1'b0; wr = 1'b0; sensor_sync = '0;
  endtask

  task automatic test_basic_cycle();
    do_reset();
    for (int i = 0; i < 34; i++) begin
      step();
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL basic cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_extension();
    do_reset();
    sensor_sync = 2'b01;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL ext cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
    end
    sensor_sync = '0;
  endtask

  task automatic test_walk();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      wr = (i == 2);
      step();
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL walk cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
    end
    wr = 1'b0;
  endtask

  task automatic test_prog();
    int guard = 0;
    do_reset();
    while (!(m_phase == "GREEN" && m_road == 1 && m_left == 3) && guard < 60) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 60) $display("[TB] FAIL prog_wait: got timeout want road1 green");
    else passes++;
    prog_sync = 1'b1; prog_sel = 2'd2; prog_val = '0;
    step();
    prog_sync = 1'b0; prog_sel = 2'd3;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL prog cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
      step();
    end
  endtask

  task automatic test_reset_prog();
    reset_sync = 1'b1; prog_sync = 1'b1; prog_sel = 2'd0; prog_val = 4'd9; tick = 1'b1;
    step();
    reset_sync = 1'b0; prog_sync = 1'b0; prog_sel = 2'd3;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL reset_prog cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
      step();
    end
  endtask

  task automatic test_tick_gated();
    bit saw_walk = 0;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      tick = (i % 4 == 3);
      wr = (i == 2) || (m_phase == "YELLOW" && m_left == 1 && tick);
      step();
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL gated cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
      if (m_phase == "WALK" && !saw_walk) begin
        saw_walk = 1;
        checks++;
        if (wr_pending !== 1'b1) $display("[TB] FAIL walk_entry_wr: got %b want 1", wr_pending);
        else passes++;
      end
    end
    wr = 1'b0; tick = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick        = ($urandom_range(0, 3) != 0);
      sensor_sync = N'($urandom);
      wr          = ($urandom_range(0, 15) == 0);
      prog_sync   = ($urandom_range(0, 60) == 0);
      prog_sel    = 2'($urandom);
      prog_val    = TW'($urandom);
      reset_sync  = ($urandom_range(0, 300) == 0);
      step();
      checks++;
      if ({lights, walk, active_road, wr_pending} !== exp_vec())
        $display("[TB] FAIL random cyc%0d: got %b want %b", i, {lights, walk, active_road, wr_pending}, exp_vec());
      else passes++;
    end
    reset_sync = 1'b0; prog_sync = 1'b0; wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
    test_extension();
    test_walk();
    test_prog();
    test_reset_prog();
    test_tick_gated();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
